// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe move controller: owns the board, enforces legal moves, alternates turns, and resolves win/draw from the detector flags.
// Optional turn-forfeit idle timer is built when MOVE_TIMEOUT_EN is defined.
module ttt_board_ctrl #(
    parameter bit FIRST_PLAYER   = 1'b0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    input  logic       win1,
    input  logic       win2,
    output logic [0:8] p1,
    output logic [0:8] p2,
    output logic       turn,
    output logic       move_err,
    output logic [1:0] winner,
    output logic       draw,
    output logic       game_over,
    output logic       timeout
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [0:8] p1_n, p2_n;
    logic       turn_n;
    logic [3:0] count, count_n;
    logic [1:0] winner_n;
    logic       draw_n;
    logic       move_err_n;
    logic       timeout_n;
    logic [0:8] cell_mask;
    logic       cell_free;
    logic       accept;

    // A position of 9 or more shifts the single bit out entirely, leaving an empty mask.
    assign cell_mask  = 9'b1_0000_0000 >> move_pos;
    assign cell_free  = (move_pos <= 4'd8) && ((cell_mask & (p1 | p2)) == 9'b0);
    assign accept     = move_valid && (state == PLAY);
    assign move_ready = (state == PLAY);
    assign game_over  = (state == OVER);

`ifdef MOVE_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] idle_cnt, idle_cnt_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PLAY;
            p1       <= '0;
            p2       <= '0;
            turn     <= FIRST_PLAYER;
            count    <= '0;
            winner   <= 2'b00;
            draw     <= 1'b0;
            move_err <= 1'b0;
            timeout  <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            p1       <= p1_n;
            p2       <= p2_n;
            turn     <= turn_n;
            count    <= count_n;
            winner   <= winner_n;
            draw     <= draw_n;
            move_err <= move_err_n;
            timeout  <= timeout_n;
`ifdef MOVE_TIMEOUT_EN
            idle_cnt <= idle_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        p1_n       = p1;
        p2_n       = p2;
        turn_n     = turn;
        count_n    = count;
        winner_n   = winner;
        draw_n     = draw;
        move_err_n = 1'b0;
        timeout_n  = 1'b0;
`ifdef MOVE_TIMEOUT_EN
        idle_cnt_n = idle_cnt;
`endif
        if (new_game) begin
            state_n  = PLAY;
            p1_n     = '0;
            p2_n     = '0;
            turn_n   = FIRST_PLAYER;
            count_n  = '0;
            winner_n = 2'b00;
            draw_n   = 1'b0;
`ifdef MOVE_TIMEOUT_EN
            idle_cnt_n = '0;
`endif
        end else begin
            case (state)
                PLAY: begin
                    if (accept) begin
                        if (cell_free) begin
                            if (turn) p2_n = p2 | cell_mask;
                            else      p1_n = p1 | cell_mask;
                            count_n = (count == 4'd9) ? 4'd9 : count + 4'd1;
                            state_n = CHECK;
                        end else begin
                            move_err_n = 1'b1;
                        end
`ifdef MOVE_TIMEOUT_EN
                        idle_cnt_n = '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        turn_n     = ~turn;
                        timeout_n  = 1'b1;
                        idle_cnt_n = '0;
                    end else begin
                        idle_cnt_n = idle_cnt + 16'd1;
`endif
                    end
                end
                CHECK: begin
                    // The detector flags reflect the board written on the previous edge.
                    if (win1) begin
                        winner_n = 2'b01;
                        state_n  = OVER;
                    end else if (win2) begin
                        winner_n = 2'b10;
                        state_n  = OVER;
                    end else if (count == 4'd9) begin
                        draw_n  = 1'b1;
                        state_n = OVER;
                    end else begin
                        turn_n  = ~turn;
                        state_n = PLAY;
`ifdef MOVE_TIMEOUT_EN
                        idle_cnt_n = '0;
`endif
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Directed self-checking bench for ttt_board_ctrl; a small line detector closes the win1/win2 loop.
module tb_ttt_board_ctrl;

    logic       clk;
    logic       rst_n;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic       win1;
    logic       win2;
    logic [0:8] p1;
    logic [0:8] p2;
    logic       turn;
    logic       move_err;
    logic [1:0] winner;
    logic       draw;
    logic       game_over;
    logic       timeout;

    int testCount = 0;
    int failCount = 0;

    ttt_board_ctrl #(.FIRST_PLAYER(1'b0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .move_valid(move_valid), .move_pos(move_pos), .move_ready(move_ready),
        .win1(win1), .win2(win2), .p1(p1), .p2(p2), .turn(turn),
        .move_err(move_err), .winner(winner), .draw(draw),
        .game_over(game_over), .timeout(timeout)
    );

    function automatic logic hasLine(input logic [0:8] b);
        hasLine = (b[0] && b[1] && b[2]) || (b[3] && b[4] && b[5]) ||
                  (b[6] && b[7] && b[8]) || (b[0] && b[3] && b[6]) ||
                  (b[1] && b[4] && b[7]) || (b[2] && b[5] && b[8]) ||
                  (b[0] && b[4] && b[8]) || (b[2] && b[4] && b[6]);
    endfunction

    assign win1 = hasLine(p1);
    assign win2 = hasLine(p2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs at the falling edge, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic valid, input logic [3:0] pos);
        @(negedge clk);
        move_valid = valid;
        move_pos   = pos;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic playMove(input logic [3:0] pos);
        applyStimulus(1'b1, pos);
        tick(1);
    endtask

    task automatic startNewGame();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
    endtask

    int rowMoves[4]  = '{0, 3, 1, 4};
    int drawMoves[8] = '{0, 1, 2, 4, 3, 5, 7, 6};
    int diagMoves[5] = '{0, 2, 1, 4, 3};

    initial begin
        rst_n      = 1'b0;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        tick(2);
        checkOutput("reset_p1", 16'(p1), 16'h000);
        checkOutput("reset_p2", 16'(p2), 16'h000);
        checkOutput("reset_turn", 16'(turn), 16'd0);
        checkOutput("reset_ready", 16'(move_ready), 16'd1);
        checkOutput("reset_flags", {11'd0, winner, draw, game_over, move_err, timeout}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Row win for player1 across the top row
        foreach (rowMoves[i]) playMove(4'(rowMoves[i]));
        applyStimulus(1'b1, 4'd2);
        checkOutput("row_p1", 16'(p1), 16'(9'b111000000));
        checkOutput("row_p2", 16'(p2), 16'(9'b000110000));
        checkOutput("row_ready_check", 16'(move_ready), 16'd0);
        checkOutput("row_over_early", 16'(game_over), 16'd0);
        tick(1);
        checkOutput("row_winner", 16'(winner), 16'd1);
        checkOutput("row_over", 16'(game_over), 16'd1);
        checkOutput("row_ready_over", 16'(move_ready), 16'd0);

        startNewGame();
        checkOutput("ng_board", {7'd0, p1 | p2}, 16'd0);
        checkOutput("ng_state", {12'd0, turn, move_ready, game_over, winner[0]}, 16'b0100);

        // Occupied cell, then out-of-range position
        playMove(4'd4);
        checkOutput("ill_p1", 16'(p1), 16'(9'b000010000));
        checkOutput("ill_turn", 16'(turn), 16'd1);
        applyStimulus(1'b1, 4'd4);
        checkOutput("ill_err", 16'(move_err), 16'd1);
        checkOutput("ill_p2", 16'(p2), 16'd0);
        checkOutput("ill_turn_held", 16'(turn), 16'd1);
        checkOutput("ill_ready", 16'(move_ready), 16'd1);
        applyStimulus(1'b0, 4'd0);
        checkOutput("ill_err_pulse", 16'(move_err), 16'd0);
        applyStimulus(1'b1, 4'd9);
        checkOutput("ill_err_range", 16'(move_err), 16'd1);
        checkOutput("ill_board_range", {p1, 7'd0} | 16'(p2), {9'b000010000, 7'd0});
        startNewGame();

        // Full board with no line
        foreach (drawMoves[i]) playMove(4'(drawMoves[i]));
        applyStimulus(1'b1, 4'd8);
        checkOutput("draw_p1", 16'(p1), 16'(9'b101100011));
        checkOutput("draw_p2", 16'(p2), 16'(9'b010011100));
        tick(1);
        checkOutput("draw_flag", 16'(draw), 16'd1);
        checkOutput("draw_winner", 16'(winner), 16'd0);
        checkOutput("draw_over", 16'(game_over), 16'd1);
        startNewGame();

        // Anti-diagonal win for player2, then moves in OVER are ignored
        foreach (diagMoves[i]) playMove(4'(diagMoves[i]));
        applyStimulus(1'b1, 4'd6);
        tick(1);
        checkOutput("diag_p2", 16'(p2), 16'(9'b001010100));
        checkOutput("diag_winner", 16'(winner), 16'd2);
        checkOutput("diag_turn", 16'(turn), 16'd1);
        applyStimulus(1'b1, 4'd5);
        checkOutput("over_err", 16'(move_err), 16'd0);
        checkOutput("over_p1", 16'(p1), 16'(9'b110100000));
        checkOutput("over_winner", 16'(winner), 16'd2);
        startNewGame();
        checkOutput("diag_ng", {5'd0, p1 | p2, turn, move_ready}, 16'd1);

        // new_game overrides a simultaneous move
        playMove(4'd0);
        checkOutput("sim_turn_before", 16'(turn), 16'd1);
        @(negedge clk);
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_pos   = 4'd4;
        @(posedge clk);
        #1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        checkOutput("sim_board", {7'd0, p1 | p2}, 16'd0);
        checkOutput("sim_err", 16'(move_err), 16'd0);
        checkOutput("sim_turn", 16'(turn), 16'd0);

        // Asynchronous reset while in CHECK
        applyStimulus(1'b1, 4'd4);
        checkOutput("rst_check_state", 16'(move_ready), 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_p1", 16'(p1), 16'd0);
        checkOutput("rst_async_ready", 16'(move_ready), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd8);
        checkOutput("rst_first_move", 16'(p1), 16'(9'b000000001));
        tick(1);
        checkOutput("rst_turn", 16'(turn), 16'd1);

`ifdef MOVE_TIMEOUT_EN
        startNewGame();
        tick(7);
        checkOutput("to_early", {14'd0, timeout, turn}, 16'd0);
        tick(1);
        checkOutput("to_pulse", {14'd0, timeout, turn}, 16'b11);
        checkOutput("to_board", {7'd0, p1 | p2}, 16'd0);
        tick(1);
        checkOutput("to_pulse_end", 16'(timeout), 16'd0);
        tick(6);
        applyStimulus(1'b1, 4'd0);
        checkOutput("to_accept_wins", 16'(timeout), 16'd0);
        checkOutput("to_accept_p2", 16'(p2), 16'(9'b100000000));
`else
        startNewGame();
        tick(20);
        checkOutput("to_disabled", {14'd0, timeout, turn}, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ttt_board_ctrl.md
Name: ttt_board_ctrl

Overview:
- Sequential move controller that owns the tic-tac-toe board and produces the two 9-bit player occupancy vectors consumed by the combinational winner detector.
- Accepts moves over a valid/ready handshake, enforces legality, alternates turns and counts moves.
- Samples the detector's win flags back and declares win/draw/game-over.
- Sits between the player input front-end and the winner detector.

Parameters:
- FIRST_PLAYER, 0, player who moves first after reset/new_game (0 = player1, 1 = player2).
- TIMEOUT_CYCLES, 1000, idle cycles in PLAY before turn forfeit; used only with MOVE_TIMEOUT_EN; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- new_game  input  1  synchronous clear of board and game state; highest priority after reset
- move_valid  input  1  move request
- move_pos  input  4  cell index 0..8; 0-2 top row left to right, 3-5 middle, 6-8 bottom
- move_ready  output  1  high in PLAY only
- win1  input  1  player1 win flag from detector, combinational from p1
- win2  input  1  player2 win flag from detector, combinational from p2
- p1  output  [0:8]  player1 occupancy; bit i = cell i; bit 0 is MSB
- p2  output  [0:8]  player2 occupancy, same ordering
- turn  output  1  0 = player1 to move, 1 = player2 to move
- move_err  output  1  one-cycle pulse on a rejected move
- winner  output  2  00 none, 01 player1, 10 player2; 11 never driven
- draw  output  1  board full with no winner
- game_over  output  1  high in OVER
- timeout  output  1  one-cycle forfeit pulse; tied 0 without MOVE_TIMEOUT_EN

Behaviour:
- Reset (rst_n low, asynchronous): state PLAY; all of the following cleared:
  - p1 = p2 = 0
  - turn = FIRST_PLAYER
  - move count = 0
  - winner = 00, draw = 0, move_err = 0, timeout = 0
  - game_over = 0
- move_ready = 1 in PLAY only.
- States are PLAY, CHECK and OVER.
- PLAY:
  - Move accepted on an edge where move_valid && move_ready.
  - Legal move: move_pos <= 8 and bit move_pos clear in (p1 | p2). Set that bit in p1 (turn = 0) or p2 (turn = 1); count += 1; go to CHECK.
  - Illegal move: move_pos >= 9 or cell occupied. move_err = 1 for the following cycle only; board, turn and count unchanged; stay in PLAY.
- CHECK (exactly one cycle; move_ready = 0): at the next edge, win1/win2 are evaluated against the updated board.
  - win1 = 1: winner = 01, go to OVER. win1 takes priority; both flags set is unreachable under legal play.
  - else win2 = 1: winner = 10, go to OVER.
  - else count == 9: draw = 1, go to OVER.
  - else: toggle turn, return to PLAY.
- Latency: board visible on p1/p2 one edge after accept; winner/draw/game_over valid one edge after that.
- OVER: move_ready = 0; move_valid ignored with no move_err; outputs held until new_game or reset.
- new_game, any state: next edge returns to the full reset values. It overrides a simultaneous move, which is dropped with no error.
- Move count: 4 bits, saturates at 9; no wrap.
- All outputs are registered. Only the win1/win2 paths are combinational feedback, and they are sampled in CHECK only.

Optional Feature:
- MOVE_TIMEOUT_EN defined:
  - 16-bit idle counter runs in PLAY; it clears on any accepted move (legal or illegal), on entry to PLAY, and on new_game.
  - When the counter reaches TIMEOUT_CYCLES-1 with no accept on that edge: toggle turn, board unchanged, count unchanged, timeout = 1 for one cycle, counter restarts.
  - If an accept and the timeout coincide, the accept wins.
  - Counter is frozen in CHECK and OVER.
- MOVE_TIMEOUT_EN undefined: no counter; timeout tied 0; TIMEOUT_CYCLES unused.

Test Plan:
- Row win: P1 0, P2 3, P1 1, P2 4, P1 2 -> p1 = 9'b111000000, p2 = 9'b000110000, winner = 01, game_over = 1 one edge after the final board update; move_ready = 0 afterwards.
- Illegal moves: P1 4, then P2 4 -> move_err pulses one cycle, turn stays 1, p2 = 0. Then move_pos = 9 -> move_err again, no board change.
- Draw: P1 0, P2 1, P1 2, P2 4, P1 3, P2 5, P1 7, P2 6, P1 8 -> p1 = 9'b101100011, p2 = 9'b010011100, draw = 1, winner = 00, game_over = 1.
- Diagonal win with P2: P1 0, P2 2, P1 1, P2 4, P1 3, P2 6 -> winner = 10. Then move_valid in OVER -> no change, no move_err. Then new_game -> p1 = p2 = 0, turn = 0, PLAY.
- Reset mid-operation: assert rst_n low during CHECK, between clock edges -> outputs clear immediately. After release, the first legal move is accepted normally.
- MOVE_TIMEOUT_EN with TIMEOUT_CYCLES = 8: no move for 8 cycles in PLAY -> timeout pulse, turn 0 -> 1, board unchanged. An accept on the 8th cycle -> no timeout.
